// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB.
// Optional fetch timeout into a sticky FAULT state, enabled by SEQ_FETCH_TIMEOUT_EN.
module core_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        imem_valid,
  input  logic [2:0]  inst_type,
  input  logic [2:0]  wr_en,
  input  logic [1:0]  pc_jmp,
  input  logic        alu_eq,
  output logic        imem_req,
  output logic        ir_load,
  output logic        rf_wr,
  output logic [1:0]  wb_sel,
  output logic        pc_load,
  output logic        pc_sel,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt,
  output logic        fault
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4,
    StFault  = 3'd5
  } state_e;

  localparam logic [2:0] InstB = 3'd2;

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic        taken_q, taken_d;
  logic [31:0] retire_q;
  logic        tmo_hit;

`ifdef SEQ_FETCH_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  // Counter is held at zero outside FETCH, so every FETCH entry starts from zero.
  always_comb begin
    tmo_d = 8'd0;
    if (state_q == StFetch) begin
      tmo_d = imem_valid ? tmo_q : tmo_q + 8'd1;
    end
  end

  assign tmo_hit = (state_q == StFetch) && !imem_valid &&
                   (({24'd0, tmo_q} + 32'd1) == FETCH_TIMEOUT);
  assign fault   = (state_q == StFault);

  // Fetch wait counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= 8'd0;
    else     tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^FETCH_TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign fault          = 1'b0;
`endif

  // Next-state, halt latch, branch decision and per-state strobes.
  always_comb begin
    state_d  = state_q;
    halt_d   = halt_q;
    taken_d  = taken_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    rf_wr    = 1'b0;
    wb_sel   = 2'd0;
    pc_load  = 1'b0;
    pc_sel   = 1'b0;
    unique case (state_q)
      StIdle: begin
        halt_d = 1'b0;
        if (start && !halt) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        halt_d   = halt_q | halt;
        if (imem_valid) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end else if (tmo_hit) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        halt_d  = halt_q | halt;
        state_d = StExec;
      end
      StExec: begin
        halt_d  = halt_q | halt;
        taken_d = (pc_jmp == 2'd3) || ((pc_jmp == 2'd1) && alu_eq) ||
                  ((pc_jmp == 2'd2) && !alu_eq);
        state_d = StWb;
      end
      StWb: begin
        // A WB coincident with reset must not commit anything.
        pc_load = !rst;
        pc_sel  = taken_q;
        rf_wr   = !rst && (wr_en != 3'd0) && (inst_type != InstB);
        if (wr_en[0])               wb_sel = 2'd0;
        else if (wr_en[2:1] == 2'd2) wb_sel = 2'd1;
        else if (wr_en[2:1] == 2'd3) wb_sel = 2'd2;
        halt_d  = 1'b0;
        state_d = (halt_q || halt) ? StIdle : StFetch;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, halt latch, taken flag and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      halt_q   <= 1'b0;
      taken_q  <= 1'b0;
      retire_q <= 32'd0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      taken_q <= taken_d;
      if (state_q == StWb) retire_q <= retire_q + 32'd1;
    end
  end

  assign state      = state_q;
  assign retire_cnt = retire_q;

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 16: cycles FETCH waits for imem_valid before the fetch-timeout fault; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  leaves IDLE and begins fetching; sampled only in IDLE.
REQ-005 halt  in  1  request to stop after the current instruction retires.
REQ-006 imem_valid  in  1  instruction word present on the fetch bus this cycle.
REQ-007 inst_type  in  3  decoded class: R=0, I=1, B=2, J=3, U=4.
REQ-008 wr_en  in  3  decoded writeback code: bit0 selects ALU result; bits[2:1]=2 selects PC+4; bits[2:1]=3 selects immediate.
REQ-009 pc_jmp  in  2  decoded jump code: 0 none, 1 taken-if-equal, 2 taken-if-not-equal, 3 unconditional.
REQ-010 alu_eq  in  1  ALU equality flag; valid in EXEC.
REQ-011 imem_req  out  1  fetch request.
REQ-012 ir_load  out  1  load instruction register.
REQ-013 rf_wr  out  1  register-file write strobe.
REQ-014 wb_sel  out  2  writeback source: 0 ALU, 1 PC+4, 2 immediate.
REQ-015 pc_load  out  1  PC update strobe.
REQ-016 pc_sel  out  1  next PC: 0 PC+4, 1 PC+imm.
REQ-017 state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, FAULT=5.
REQ-018 retire_cnt  out  32  count of retired instructions.
REQ-019 fault  out  1  sticky fault indicator.

Function
REQ-020 IDLE SHALL go to FETCH on start=1 with halt=0, and SHALL otherwise stay in IDLE.
REQ-021 In FETCH, imem_req SHALL be 1; when imem_valid=1, ir_load SHALL pulse for that cycle only and the next state SHALL be DECODE; otherwise the state SHALL stay FETCH.
REQ-022 DECODE SHALL last exactly 1 cycle and then go to EXEC.
REQ-023 EXEC SHALL last exactly 1 cycle, SHALL register the branch decision taken=(pc_jmp==3)|(pc_jmp==1&alu_eq)|(pc_jmp==2&!alu_eq), and then go to WB.
REQ-024 WB SHALL last 1 cycle and SHALL pulse pc_load, with pc_sel equal to the registered taken value.
REQ-025 In WB, rf_wr SHALL be 1 iff wr_en!=0, with wb_sel = 0 if wr_en[0], 1 if wr_en[2:1]==2, 2 if wr_en[2:1]==3; wr_en[0] SHALL win if both encodings are set.
REQ-026 In WB, retire_cnt SHALL increment by 1 and wrap from 0xFFFFFFFF to 0.
REQ-027 After WB, the next state SHALL be IDLE if halt was seen at any cycle since the last FETCH entry, otherwise FETCH.
REQ-028 Minimum instruction latency SHALL be 4 cycles (FETCH with immediate valid, DECODE, EXEC, WB).
REQ-029 Outside the states named above, ir_load, rf_wr, pc_load, pc_sel and imem_req SHALL be 0 and wb_sel SHALL be 0.
REQ-030 inst_type=B SHALL force rf_wr=0 regardless of wr_en.
REQ-031 FAULT SHALL hold fault=1 and all strobes at 0 until rst.

Reset
REQ-032 On rst=1 at a clock edge, state SHALL become IDLE, retire_cnt SHALL become 0, fault SHALL become 0, and the halt latch and taken register SHALL clear.
REQ-033 Reset SHALL take priority over every transition, including mid-FETCH and WB; a WB cycle coincident with rst SHALL neither retire nor write.

Configuration
REQ-034 With macro SEQ_FETCH_TIMEOUT_EN defined, a counter SHALL clear on FETCH entry and increment each FETCH cycle without imem_valid; on reaching FETCH_TIMEOUT, the next state SHALL be FAULT, and imem_valid in that same cycle SHALL take priority.
REQ-035 Without SEQ_FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, FAULT SHALL be unreachable, and fault SHALL be tied to 0.

Verification
REQ-036 rst, start pulse, imem_valid always 1, R-type (wr_en=1, pc_jmp=0) -> states 1,2,3,4 repeat; rf_wr=1 with wb_sel=0 in WB; pc_sel=0; retire_cnt=3 after 12 cycles.
REQ-037 B-type, pc_jmp=1, alu_eq=1 -> WB has pc_sel=1, rf_wr=0; then pc_jmp=2, alu_eq=1 -> pc_sel=0.
REQ-038 J-type (wr_en=3'b100, pc_jmp=3) -> rf_wr=1, wb_sel=1, pc_sel=1; U-type (wr_en=3'b110) -> wb_sel=2, pc_sel=0.
REQ-039 halt pulsed during DECODE -> instruction retires and state=0 the cycle after WB; start while halt=1 -> stays IDLE.
REQ-040 Macro defined, FETCH_TIMEOUT=4, imem_valid held 0 -> state=5 and fault=1 after 4 FETCH cycles, held until rst; macro undefined -> FETCH persists for 100 cycles with fault=0.
REQ-041 rst asserted in WB with retire_cnt=7 -> retire_cnt=0, rf_wr=0, state=0 on the next cycle.
